// File: rtl/fp_mul_scheduler_pkg.sv
// Shared constants, types and index helpers for the FP32 multiplier scheduler.
// Types here describe the default configuration; the scheduler sizes its own ids from NUM_REQ.
package fp_mul_scheduler_pkg;

  localparam int FP_MUL_LATENCY   = 3;
  localparam int FP_SCHED_NUM_REQ = 4;
  localparam int FP_SCHED_ID_W    = $clog2(FP_SCHED_NUM_REQ);

  typedef logic [FP_SCHED_ID_W-1:0] fp_sched_id_t;

  typedef struct packed {
    logic         valid;
    fp_sched_id_t id;
  } fp_inflight_t;

  // Modulo increment for indices whose range need not be a power of two.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned modulus);
    return (idx + 1 >= modulus) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fp_mul_scheduler_if.sv
// Requester and response handshake bundle for fp_mul_scheduler.
// master = requesters/consumer side, slave = scheduler side.
interface fp_mul_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic                          resp_valid;
  logic                          resp_ready;
  logic [ID_W-1:0]               resp_id;
  logic [DATA_WIDTH-1:0]         resp_data;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data
  );

endinterface

// File: rtl/fp_mul_scheduler_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first req at or after ptr.
// Zero latency; grant is all-zero when enable is low or no req is set.
module fp_rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (enable && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mul_scheduler.sv
// Shares one fixed-latency FP32 multiplier among NUM_REQ requesters; handshake to resp_valid is MUL_LATENCY+2 cycles.
// Credit-gated issue keeps the response FIFO from overflowing; optional counters under FP_MUL_SCHED_STATS_EN.
module fp_mul_scheduler
  import fp_mul_scheduler_pkg::*;
#(
  parameter int NUM_REQ     = FP_SCHED_NUM_REQ,
  parameter int MUL_LATENCY = FP_MUL_LATENCY,
  parameter int FIFO_DEPTH  = 4,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_mul_scheduler_if.slave     bus,
  output logic [DATA_WIDTH-1:0] mul_a,
  output logic [DATA_WIDTH-1:0] mul_b,
  input  logic [DATA_WIDTH-1:0] mul_result
`ifdef FP_MUL_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_stall
`endif
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int STAGES = MUL_LATENCY + 1;

  if (FIFO_DEPTH < MUL_LATENCY) begin : g_bad_depth
    $fatal(1, "fp_mul_scheduler: FIFO_DEPTH must be >= MUL_LATENCY");
  end
  if (DATA_WIDTH != 32) begin : g_bad_width
    $fatal(1, "fp_mul_scheduler: DATA_WIDTH must be 32");
  end

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } inflight_t;

  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  inflight_t             infl_q [STAGES];
  inflight_t             infl_d [STAGES];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
  logic [ID_W-1:0]       fifo_id_q [FIFO_DEPTH];
  logic [ID_W-1:0]       fifo_id_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  int                    inflight_cnt;
  int                    credits;
  logic                  has_credit;
  logic [NUM_REQ-1:0]    grant;
  logic                  issue;
  logic [ID_W-1:0]       grant_id;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;
  logic                  push, pop, resp_vld;

  // Credits count every op that still needs a FIFO slot: buffered plus in the pipe.
  always_comb begin
    inflight_cnt = 0;
    for (int s = 0; s < STAGES; s++) begin
      inflight_cnt += int'(infl_q[s].valid);
    end
    credits    = FIFO_DEPTH - int'(count_q) - inflight_cnt;
    has_credit = (credits > 0);
  end

  fp_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req    (bus.req_valid),
    .ptr    (rr_ptr_q),
    .enable (has_credit && rst_n),
    .grant  (grant)
  );

  assign bus.req_ready = grant;
  assign issue         = |grant;

  always_comb begin
    grant_id = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id = ID_W'(i);
        sel_a    = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b    = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Stage 0 is loaded on the same edge as the operand register, so the last
  // stage lines up with the cycle mul_result carries this op's product.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    if (issue) begin
      rr_ptr_d = ID_W'(next_idx(int'(grant_id), NUM_REQ));
      mul_a_d  = sel_a;
      mul_b_d  = sel_b;
    end
    infl_d[0] = '{valid: issue, id: grant_id};
    for (int s = 1; s < STAGES; s++) begin
      infl_d[s] = infl_q[s-1];
    end
  end

  assign push     = infl_q[STAGES-1].valid;
  assign resp_vld = (count_q != '0);
  assign pop      = resp_vld && bus.resp_ready;

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_id_d   = fifo_id_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = mul_result;
      fifo_id_d[wr_ptr_q]   = infl_q[STAGES-1].id;
      wr_ptr_d              = PTR_W'(next_idx(int'(wr_ptr_q), FIFO_DEPTH));
    end
    if (pop) begin
      rd_ptr_d = PTR_W'(next_idx(int'(rd_ptr_q), FIFO_DEPTH));
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int s = 0; s < STAGES; s++) begin
        infl_q[s] <= '0;
      end
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        fifo_data_q[e] <= '0;
        fifo_id_q[e]   <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      infl_q      <= infl_d;
      fifo_data_q <= fifo_data_d;
      fifo_id_q   <= fifo_id_d;
    end
  end

  assign mul_a          = mul_a_q;
  assign mul_b          = mul_b_q;
  assign bus.resp_valid = resp_vld;
  assign bus.resp_data  = resp_vld ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.resp_id    = resp_vld ? fifo_id_q[rd_ptr_q] : '0;

`ifdef FP_MUL_SCHED_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_issued_d = stat_issued_q + 32'(issue);
    stat_stall_d  = stat_stall_q + 32'((|bus.req_valid) && !has_credit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Randomized bench for fp_mul_scheduler with a 3-stage behavioural FP32 multiplier
// and a queue-based reference model of grants, credits, response timing and order.
module tb_fp_mul_scheduler;
  import fp_mul_scheduler_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] mul_a, mul_b;
  logic [DW-1:0] s1, s2, s3;

  fp_mul_scheduler_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

`ifdef FP_MUL_SCHED_STATS_EN
  logic [31:0] stat_issued, stat_stall;
`endif

  fp_mul_scheduler #(
    .NUM_REQ(N), .MUL_LATENCY(LAT), .FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (s3)
`ifdef FP_MUL_SCHED_STATS_EN
    ,
    .stat_issued(stat_issued),
    .stat_stall (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Normal-range FP32 multiply, truncating the mantissa.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] ma, mb, p;
    logic [22:0] m;
    int          e;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
    ma = {24'd0, 1'b1, a[22:0]};
    mb = {24'd0, 1'b1, b[22:0]};
    p  = ma * mb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], 8'(e), m};
  endfunction

  always @(posedge clk) begin
    s1 <= fmul(mul_a, mul_b);
    s2 <= s1;
    s3 <= s2;
  end

  typedef struct {
    fp_sched_id_t id;
    logic [31:0]  data;
    int           rdy_cyc;
  } exp_t;

  exp_t        q[$];
  int          mptr, cyc, nvec, nerr;
  int          vmode, rmode, hs_phase;
  int          m_issued, m_stall;
  int          single_hs_cyc = -1, single_resp_cyc = -1;
  logic [31:0] single_resp_data;
  bit          single_pending, track_first;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g = '0;
    if (q.size() >= DEPTH) return g;
    for (int k = 0; k < N; k++) begin
      if (bus.req_valid[(mptr + k) % N]) begin
        g[(mptr + k) % N] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
  endfunction

  task automatic sample();
    logic [N-1:0] hs;
    int           gid;
    int           occupied;
    exp_t         e;
    occupied = q.size();
    chk("req_ready", 64'(bus.req_ready), 64'(exp_grant()));
    chk("resp_valid", 64'(bus.resp_valid), 64'(occupied > 0 && q[0].rdy_cyc <= cyc));
    if (bus.resp_valid) begin
      if (occupied == 0) chk("stale_resp", 64'(bus.resp_valid), 64'd0);
      else begin
        chk("resp_id", 64'(bus.resp_id), 64'(q[0].id));
        chk("resp_data", 64'(bus.resp_data), 64'(q[0].data));
      end
      if (single_hs_cyc >= 0 && single_resp_cyc < 0) begin
        single_resp_cyc  = cyc;
        single_resp_data = bus.resp_data;
      end
    end
    if ((|bus.req_valid) && occupied >= DEPTH) m_stall++;
    hs = bus.req_valid & bus.req_ready;
    if (bus.resp_valid && bus.resp_ready && occupied > 0) void'(q.pop_front());
    if (hs != '0) begin
      chk("no_overflow", 64'(occupied < DEPTH), 64'd1);
      gid = 0;
      for (int i = N - 1; i >= 0; i--) if (hs[i]) gid = i;
      if (track_first) begin
        chk("first_grant_after_reset", 64'(gid), 64'd0);
        track_first = 1'b0;
      end
      e.id      = fp_sched_id_t'(gid);
      e.data    = fmul(bus.req_a[gid*DW +: DW], bus.req_b[gid*DW +: DW]);
      e.rdy_cyc = cyc + LAT + 2;
      q.push_back(e);
      mptr = (gid + 1) % N;
      m_issued++;
      hs_phase++;
      if (single_pending) begin
        single_pending = 1'b0;
        single_hs_cyc  = cyc;
      end
    end
  endtask

  task automatic drive();
    case (vmode)
      0:       bus.req_valid = '0;
      1:       bus.req_valid = '1;
      2:       bus.req_valid = N'($urandom);
      default: bus.req_valid = single_pending ? N'(1) : '0;
    endcase
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*DW +: DW] = rand_fp();
      bus.req_b[i*DW +: DW] = rand_fp();
    end
    if (vmode == 3) begin
      bus.req_a[DW-1:0] = 32'h3FC0_0000;
      bus.req_b[DW-1:0] = 32'h4000_0000;
    end
    case (rmode)
      0:       bus.resp_ready = 1'b0;
      1:       bus.resp_ready = 1'b1;
      default: bus.resp_ready = 1'($urandom);
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive();
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    vmode = 1;
    rmode = 0;
    drive();
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_id", 64'(bus.resp_id), 64'd0);
    chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_b", 64'(mul_b), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single 1.5 * 2.0 operation.
    vmode = 3;
    rmode = 1;
    single_pending = 1'b1;
    drive();
    run(12);
    chk("single_latency", 64'(single_resp_cyc - single_hs_cyc), 64'(LAT + 2));
    chk("single_product", 64'(single_resp_data), 64'h4040_0000);

    // All requesters valid, consumer always ready.
    vmode = 1;
    run(40);

    // Consumer stalled: only DEPTH ops may be accepted.
    vmode = 0;
    run(12);
    vmode = 1;
    rmode = 0;
    hs_phase = 0;
    run(20);
    chk("bp_accepted", 64'(hs_phase), 64'(DEPTH));
    chk("bp_head_held", 64'(bus.resp_valid), 64'd1);
    rmode = 1;
    hs_phase = 0;
    run(20);
    chk("bp_resume", 64'(hs_phase > DEPTH), 64'd1);

    // Random valids with a toggling consumer.
    vmode = 2;
    rmode = 2;
    run(300);

    // Asynchronous reset with work both in flight and buffered.
    vmode = 0;
    rmode = 1;
    run(12);
    vmode = 1;
    rmode = 0;
    run(6);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("arst_req_ready", 64'(bus.req_ready), 64'd0);
    q.delete();
    mptr = 0;
    m_issued = 0;
    m_stall = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vmode = 1;
    rmode = 1;
    track_first = 1'b1;
    drive();
    run(10);
    chk("first_grant_seen", 64'(track_first), 64'd0);
    vmode = 2;
    rmode = 2;
    run(200);

    vmode = 0;
    rmode = 1;
    run(20);
    chk("final_drained", 64'(bus.resp_valid), 64'd0);
`ifdef FP_MUL_SCHED_STATS_EN
    chk("stat_issued", 64'(stat_issued), 64'(m_issued));
    chk("stat_stall", 64'(stat_stall), 64'(m_stall));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
